// File: rtl/lia_pkg.sv
// Shared LIA-chain definitions: sample width, max averaging window, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lia_pkg;

    localparam int LIA_DW      = 16;
    localparam int LIA_LGN_MAX = 5;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    // Window exponents above the buffer capacity fall back to the largest window.
    function automatic logic [2:0] clamp_lgn(input logic [2:0] lgn, input int lgn_max);
        logic [2:0] w_max;
        w_max = 3'(lgn_max);
        return (lgn > w_max) ? w_max : lgn;
    endfunction

endpackage

// File: rtl/fir_out_averager_if.sv
// Sample-in / result-out bundle between FIR_filter output, the averager and readout.
// Latency: n/a (wires only).
// Backpressure: ready is a level; in_valid is dropped by the slave while ready is low.
// Signals: in_valid/in_data (sample strobe + signed sample), ready (slave in RUN),
//          out_valid (1-cycle pulse), out_data (mean), out_sum (raw window sum), warm.
interface fir_out_averager_if
    import lia_pkg::*;
#(
    parameter int DW = LIA_DW,
    parameter int SW = LIA_DW + LIA_LGN_MAX
);
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic signed [SW-1:0] out_sum;
    logic                 warm;

    modport master (
        output in_valid, in_data,
        input  ready, out_valid, out_data, out_sum, warm
    );

    modport slave (
        input  in_valid, in_data,
        output ready, out_valid, out_data, out_sum, warm
    );
endinterface

// File: rtl/avg_ring_buf.sv
// Sample history for the boxcar: 2^AW x DW register array, one write, one async read.
// Latency: write visible next cycle; read is combinational (returns pre-write data).
// Backpressure: none; the caller decides when to write.
// Ports: i_clk, i_we/i_waddr/i_wdata (write), i_raddr -> o_rdata (read).
module avg_ring_buf #(
    parameter int DW = 16,
    parameter int AW = 5
)(
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    // No reset: the owner zero-fills the array in its CLEAR phase.
    logic [DW-1:0] r_mem [1 << AW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fir_out_averager.sv
// 2^lgn-point boxcar on FIR_filter samples, sliding (per sample) or block-decimated.
// Latency: accepted sample in cycle t -> out_valid pulse in t+1.
// Backpressure: ready low during CLEAR (buffer zero-fill); samples offered then are dropped.
// Ports: i_clk, i_rst (sync, active high), i_en (0 freezes everything), i_lgn, i_mode,
//        bus (slave side of fir_out_averager_if).
module fir_out_averager
    import lia_pkg::*;
#(
    parameter int DW      = LIA_DW,
    parameter int LGN_MAX = LIA_LGN_MAX
)(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [2:0] i_lgn,
    input  logic       i_mode,
    fir_out_averager_if.slave bus
);
    localparam int SW    = DW + LGN_MAX;
    localparam int AW    = LGN_MAX;
    localparam int DEPTH = 1 << LGN_MAX;
    localparam int CW    = LGN_MAX + 1;

    state_t               r_state;
    logic [2:0]           r_lgn;
    logic                 r_mode;
    logic [AW-1:0]        r_ptr;
    logic signed [SW-1:0] r_sum;
    logic [CW-1:0]        r_cnt;
    logic                 r_warm;
    logic                 r_out_valid;
    logic signed [DW-1:0] r_out_data;
    logic signed [SW-1:0] r_out_sum;

    logic [2:0]           w_lgn_eff;
    logic                 w_cfg_change;
    logic                 w_accept;
    logic [CW-1:0]        w_n;
    logic [CW-1:0]        w_cnt_inc;
    logic                 w_full;
    logic [AW-1:0]        w_raddr;
    logic [DW-1:0]        w_rdata;
    logic signed [DW-1:0] w_old;
    logic signed [SW-1:0] w_in_ext;
    logic signed [SW-1:0] w_old_ext;
    logic signed [SW-1:0] w_sum_res;
    logic signed [SW-1:0] w_mean_full;
    logic                 w_we;
    logic [DW-1:0]        w_wdata;

    assign w_lgn_eff = clamp_lgn(i_lgn, LGN_MAX);

    // A config change seen in RUN wins over a sample in the same cycle, so nothing
    // computed with the old window leaks out after the switch.
    assign w_cfg_change = (w_lgn_eff != r_lgn) || (i_mode != r_mode);
    assign w_accept     = (r_state == ST_RUN) && i_en && bus.in_valid && !w_cfg_change;

    assign w_n       = CW'(1) << r_lgn;
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_full    = (w_cnt_inc == w_n);

    // Entry leaving the window; for the full 2^LGN_MAX window this is the slot
    // about to be overwritten, read before the write lands.
    assign w_raddr   = r_ptr - w_n[AW-1:0];
    assign w_old     = w_rdata;
    assign w_in_ext  = SW'(bus.in_data);
    assign w_old_ext = SW'(w_old);
    assign w_sum_res = r_mode ? (r_sum + w_in_ext) : (r_sum + w_in_ext - w_old_ext);

    // Arithmetic shift floors toward -inf; result always fits DW.
    assign w_mean_full = w_sum_res >>> r_lgn;

    assign w_we    = ((r_state == ST_CLEAR) && i_en) || (w_accept && !r_mode);
    assign w_wdata = (r_state == ST_CLEAR) ? '0 : bus.in_data;

    avg_ring_buf #(
        .DW (DW),
        .AW (AW)
    ) u_ring (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_ptr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_CLEAR;
            r_lgn       <= '0;
            r_mode      <= 1'b0;
            r_ptr       <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_warm      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sum   <= '0;
        end else if (!i_en) begin
            r_out_valid <= 1'b0;
        end else begin
            r_lgn       <= w_lgn_eff;
            r_mode      <= i_mode;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_ptr <= r_ptr + AW'(1);
                    if (r_ptr == AW'(DEPTH - 1)) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_cfg_change) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_warm  <= 1'b0;
                    end else if (w_accept) begin
                        if (!r_mode) begin
                            r_ptr       <= r_ptr + AW'(1);
                            r_sum       <= w_sum_res;
                            r_out_valid <= 1'b1;
                            r_out_sum   <= w_sum_res;
                            r_out_data  <= DW'(w_mean_full);
                            // Counter only needed until the window first fills.
                            if (!r_warm) begin
                                r_cnt <= w_cnt_inc;
                            end
                            if (w_full) begin
                                r_warm <= 1'b1;
                            end
                        end else if (w_full) begin
                            r_out_valid <= 1'b1;
                            r_out_sum   <= w_sum_res;
                            r_out_data  <= DW'(w_mean_full);
                            r_sum       <= '0;
                            r_cnt       <= '0;
                            r_warm      <= 1'b1;
                        end else begin
                            r_sum <= w_sum_res;
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign bus.ready     = (r_state == ST_RUN);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sum   = r_out_sum;
    assign bus.warm      = r_warm;

endmodule
